// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, flag bit
// positions, FSM state encoding and the queued command layout.
package alu_pkg;

    // ALU opcodes as carried on cmd_sel / alu_sel / rsp_sel
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_EQ  = 3'b111;

    // Bit positions inside rsp_flags
    localparam int FLG_OVF  = 3;
    localparam int FLG_ZERO = 2;
    localparam int FLG_LESS = 1;
    localparam int FLG_EQ   = 0;

    // Width of one queued command {a, b, sel}
    localparam int CMD_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } cmd_t;

    // Place the four ALU flags at their named positions
    function automatic logic [3:0] pack_flags(input logic ovf, input logic zero,
                                              input logic less, input logic eq);
        logic [3:0] f;
        f           = 4'b0000;
        f[FLG_OVF]  = ovf;
        f[FLG_ZERO] = zero;
        f[FLG_LESS] = less;
        f[FLG_EQ]   = eq;
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_driver_fifo.sv
// Command queue for the ALU driver: synchronous FIFO with extra-MSB
// pointers so full/empty fall out of a pointer compare and the pointers
// wrap on their own. Push is ignored when full; pop is ignored when empty.
module cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Same index bits with differing MSB means the writer lapped the reader
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    // Advance pointers on accepted push / pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents only matter behind valid pointers so no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequential front-end for the combinational 4-bit ALU. Commands are queued,
// issued one at a time on registered alu_a/alu_b/alu_sel, the ALU outcome is
// captured one cycle later and offered on a valid/ready response port.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_less,
    input  logic       alu_equal,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic [2:0] rsp_sel,
    output logic       sticky_ovf,
    input  logic       clr_sticky,
    output logic [7:0] done_cnt,
    output logic       busy
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] alu_a_q,      alu_a_d;
    logic [3:0] alu_b_q,      alu_b_d;
    logic [2:0] alu_sel_q,    alu_sel_d;
    logic       rsp_valid_q,  rsp_valid_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic [3:0] rsp_flags_q,  rsp_flags_d;
    logic [2:0] rsp_sel_q,    rsp_sel_d;
    logic       sticky_q,     sticky_d;
    logic [7:0] done_cnt_q,   done_cnt_d;

    cmd_t       push_cmd_s;
    cmd_t       head_cmd_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    logic       push_s;
    logic       pop_s;
    logic       ovf_set_s;

    // cmd_ready is held low while reset is asserted so every output reads 0
    assign cmd_ready  = !fifo_full_s && !rst;
    assign push_s     = cmd_valid && cmd_ready;
    assign push_cmd_s = {cmd_a, cmd_b, cmd_sel};
    assign ovf_set_s  = (state_q == ST_EXEC) && alu_overflow;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .head_data (head_cmd_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: issue when work is queued, capture, then wait for handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: pop/issue in IDLE, capture in EXEC, hand off in RESP
    always_comb begin
        pop_s        = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_sel_d    = rsp_sel_q;
        done_cnt_d   = done_cnt_q;

        // A capture that reports overflow beats a simultaneous clear
        if (ovf_set_s) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    alu_a_d   = head_cmd_s.a;
                    alu_b_d   = head_cmd_s.b;
                    alu_sel_d = head_cmd_s.sel;
                end else begin
                    pop_s     = 1'b0;
                end
            end
            ST_EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_result;
                rsp_flags_d  = pack_flags(alu_overflow, alu_zero, alu_less, alu_equal);
                rsp_sel_d    = alu_sel_q;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 8'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and status registers; reset clears everything asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_sel_q    <= ALU_ADD;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 4'd0;
            rsp_flags_q  <= 4'd0;
            rsp_sel_q    <= 3'd0;
            sticky_q     <= 1'b0;
            done_cnt_q   <= 8'd0;
        end else begin
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_sel_q    <= rsp_sel_d;
            sticky_q     <= sticky_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_sel    = rsp_sel_q;
    assign sticky_ovf = sticky_q;
    assign done_cnt   = done_cnt_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a behavioural ALU drives the DUT's ALU inputs,
// a negedge monitor keeps an in-order scoreboard of accepted commands, and
// directed sequences cover latency, flags, sticky overflow, backpressure,
// counter wrap and asynchronous reset.
module tb_alu_cmd_driver;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } tcmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_sel;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_overflow, alu_zero, alu_less, alu_equal;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_result, rsp_flags;
    logic [2:0] rsp_sel;
    logic       sticky_ovf, clr_sticky;
    logic [7:0] done_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard state
    tcmd_t      mq[$];
    bit         acc_p, hs_p, clr_p, rv_p;
    tcmd_t      acc_cmd;
    logic [7:0] done_m;
    bit         sticky_m;
    bit         wrapped = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_sel      (cmd_sel),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_less     (alu_less),
        .alu_equal    (alu_equal),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_sel      (rsp_sel),
        .sticky_ovf   (sticky_ovf),
        .clr_sticky   (clr_sticky),
        .done_cnt     (done_cnt),
        .busy         (busy)
    );

    // Behavioural ALU: returns {result[3:0], ovf, zero, less, equal}
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] sel);
        logic [3:0] r;
        logic ovf, z, lt, eq;
        r = 4'd0; ovf = 1'b0; z = 1'b0; lt = 1'b0; eq = 1'b0;
        case (sel)
            3'd0: begin r = a + b; ovf = (a[3] == b[3]) && (r[3] != a[3]); z = (r == 4'd0); end
            3'd1: begin r = a - b; ovf = (a[3] != b[3]) && (r[3] != a[3]); z = (r == 4'd0); end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin r = a - b; lt = ($signed(a) < $signed(b)); end
            default: begin r = a - b; eq = (a == b); end
        endcase
        return {r, ovf, z, lt, eq};
    endfunction

    always_comb begin
        {alu_result, alu_overflow, alu_zero, alu_less, alu_equal} = alu_model(alu_a, alu_b, alu_sel);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: apply last edge's accept/handoff, then compare DUT state
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        bit rise;
        e = 8'd0;
        if (rst) begin
            mq.delete();
            done_m   = 8'd0;
            sticky_m = 1'b0;
            acc_p = 1'b0; hs_p = 1'b0; clr_p = 1'b0; rv_p = 1'b0;
        end else begin
            if (acc_p) mq.push_back(acc_cmd);
            if (hs_p) begin
                if (mq.size() > 0) mq.delete(0);
                done_m = done_m + 8'd1;
                if (done_m == 8'd0) wrapped = 1'b1;
            end
            rise = rsp_valid && !rv_p;
            if (rsp_valid) begin
                if (mq.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = alu_model(mq[0].a, mq[0].b, mq[0].sel);
                    chk("sb_result", rsp_result, e[7:4]);
                    chk("sb_flags", rsp_flags, e[3:0]);
                    chk("sb_sel", rsp_sel, mq[0].sel);
                end
            end
            if (rise && e[3]) sticky_m = 1'b1;
            else if (clr_p) sticky_m = 1'b0;
            chk("sb_done_cnt", done_cnt, done_m);
            chk("sb_sticky", sticky_ovf, sticky_m);
            chk("sb_busy", busy, mq.size() != 0);
            acc_p   = cmd_valid && cmd_ready;
            acc_cmd = {cmd_a, cmd_b, cmd_sel};
            hs_p    = rsp_valid && rsp_ready;
            clr_p   = clr_sticky;
            rv_p    = rsp_valid;
        end
    end

    // Push one command from idle, check latency and the captured response
    task automatic run_one(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] sel, input logic [3:0] er, input logic [3:0] ef);
        int lat;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_result"}, rsp_result, er);
        chk({tag, "_flags"}, rsp_flags, ef);
        chk({tag, "_sel"}, rsp_sel, sel);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_flags"}, rsp_flags, 0);
        chk({tag, "_rsp_sel"}, rsp_sel, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_sel"}, alu_sel, 0);
        chk({tag, "_sticky"}, sticky_ovf, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin : stim
        int n_acc, cyc, ready_cyc, guard;
        int rc[$];
        bit pv;

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_sel = 3'd0;
        rsp_ready = 1'b0; clr_sticky = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);

        // basic add, overflow add, clear, signed-less, equal
        run_one("add", 4'd3, 4'd4, 3'b000, 4'd7, 4'b0000);
        @(negedge clk);
        chk("done_first", done_cnt, 1);
        run_one("ovf", 4'd7, 4'd1, 3'b000, 4'd8, 4'b1000);
        @(negedge clk);
        chk("sticky_set", sticky_ovf, 1);
        @(posedge clk); #1; clr_sticky = 1'b1;
        @(posedge clk); #1; clr_sticky = 1'b0;
        chk("sticky_clr", sticky_ovf, 0);
        run_one("slt", 4'd2, 4'd5, 3'b110, 4'b1101, 4'b0010);
        run_one("eq", 4'd9, 4'd9, 3'b111, 4'd0, 4'b0001);

        // overflow capture coinciding with clr_sticky: set wins
        clr_sticky = 1'b1;
        run_one("setwin", 4'd7, 4'd1, 3'b000, 4'd8, 4'b1000);
        chk("setwin_sticky", sticky_ovf, 1);
        @(posedge clk); #1; clr_sticky = 1'b0;
        chk("setwin_then_clr", sticky_ovf, 0);

        // backpressure: fill RESP plus FIFO
        @(posedge clk); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b1;
        n_acc = 0;
        repeat (12) begin
            cmd_a = 4'($urandom_range(0, 15)); cmd_b = 4'($urandom_range(0, 15));
            cmd_sel = 3'($urandom_range(0, 7));
            @(negedge clk);
            if (cmd_ready) n_acc++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("full_accepts", n_acc, 5);
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        cyc = 0; ready_cyc = -1; pv = 1'b1;
        while (cyc < 40 && rc.size() < 4) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid && !pv) rc.push_back(cyc);
            pv = rsp_valid;
            if (cmd_ready && ready_cyc < 0) ready_cyc = cyc;
        end
        chk("drain_ready_cycle", ready_cyc, 3);
        chk("drain_rsp_count", rc.size(), 4);
        if (rc.size() > 0) chk("drain_first_rise", rc[0], 4);
        for (int i = 1; i < rc.size(); i++) chk("drain_spacing", rc[i] - rc[i-1], 3);

        // randomized traffic, long enough to wrap done_cnt
        repeat (2000) begin
            @(posedge clk); #1;
            cmd_valid  = ($urandom_range(0, 9) < 6);
            cmd_a      = 4'($urandom_range(0, 15));
            cmd_b      = 4'($urandom_range(0, 15));
            cmd_sel    = 3'($urandom_range(0, 7));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; clr_sticky = 1'b0; rsp_ready = 1'b1;
        guard = 0;
        while (busy && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk("random_drain_busy", busy, 0);
        chk("done_cnt_wrapped", wrapped, 1);

        // reset while EXEC with two commands queued
        @(posedge clk); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b1;
        cmd_a = 4'd1; cmd_b = 4'd2; cmd_sel = 3'b000;
        @(posedge clk); #1;
        cmd_a = 4'd5; cmd_b = 4'd6; cmd_sel = 3'b101;
        @(posedge clk); #1;
        cmd_a = 4'd7; cmd_b = 4'd7; cmd_sel = 3'b111;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rst_pre_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_exec_a", alu_a, 5);
        chk("rst_pre_exec_sel", alu_sel, 3'b101);
        chk("rst_pre_exec_valid", rsp_valid, 0);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #2;
        rst = 1'b0; rsp_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("no_stale_valid", rsp_valid, 0);
            chk("no_stale_busy", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
